// File: rtl/garegga_prog_pkg.sv
// rtl/garegga_prog_pkg.sv - shared types for the ROM-download write responder
package garegga_prog_pkg;

  localparam int PROG_AW = 22;
  localparam logic [1:0] MASK_RST = 2'b11;

  typedef struct packed {
    logic [PROG_AW-1:0] addr;
    logic [1:0]         ba;
    logic [15:0]        data;
    logic [1:0]         mask;
  } prog_entry_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} drain_state_t;

endpackage

// File: rtl/garegga_prog_fifo.sv
// rtl/garegga_prog_fifo.sv - request FIFO with push/pop and merge-into-tail
module garegga_prog_fifo
  import garegga_prog_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  prog_entry_t              push_entry,
  input  logic                     pop,
  input  logic                     merge,
  input  prog_entry_t              merge_entry,
  output prog_entry_t              head,
  output prog_entry_t              tail,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  prog_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] tail_ptr;

  assign tail_ptr = wr_ptr - 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the top masks the head fields while empty.
  always_ff @(posedge clk) begin
    if (push)       mem[wr_ptr]   <= push_entry;
    else if (merge) mem[tail_ptr] <= merge_entry;
  end

  assign head  = mem[rd_ptr];
  assign tail  = mem[tail_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/garegga_prog_wr.sv
// rtl/garegga_prog_wr.sv - ROM download write responder; GAREGGA_PROG_MERGE_EN enables byte merge
module garegga_prog_wr
  import garegga_prog_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = PROG_AW
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic [AW-1:0] PROG_ADDR,
  input  logic [15:0]   PROG_DATA,
  input  logic [1:0]    PROG_MASK,
  input  logic [1:0]    PROG_BA,
  input  logic          PROG_WE,
  output logic          PROG_RDY,
  input  logic          DOWNLOADING,
  output logic          PROG_BUSY,
  output logic [AW-1:0] SDR_ADDR,
  output logic [1:0]    SDR_BA,
  output logic [15:0]   SDR_DIN,
  output logic [1:0]    SDR_DIN_M,
  output logic          SDR_WR,
  input  logic          SDR_ACK,
  input  logic          SDR_RDY
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE = (PW+1)'(1);

  drain_state_t state, state_nx;
  prog_entry_t  req_entry, merge_entry, head, tail;
  logic [PW:0]  count;
  logic         full, empty, taken;
  logic         accept, push, pop, merge, merge_ok, remaining;
  logic         unused_downloading;

  assign unused_downloading = DOWNLOADING;

  assign req_entry = '{addr: PROG_AW'(PROG_ADDR), ba: PROG_BA, data: PROG_DATA, mask: PROG_MASK};

`ifdef GAREGGA_PROG_MERGE_EN
  // The tail may only absorb bytes while it is not the entry being handed to the controller.
  assign merge_ok = !empty && (tail.addr == req_entry.addr) && (tail.ba == PROG_BA) &&
                    ((~PROG_MASK & ~tail.mask) == 2'b00) && !(count == ONE && state != IDLE);
  assign merge_entry = '{addr: tail.addr, ba: tail.ba,
                         data: {PROG_MASK[1] ? tail.data[15:8] : PROG_DATA[15:8],
                                PROG_MASK[0] ? tail.data[7:0]  : PROG_DATA[7:0]},
                         mask: PROG_MASK & tail.mask};
`else
  assign merge_ok    = 1'b0;
  assign merge_entry = tail;
`endif

  // A pop frees a slot in the same cycle, so a full FIFO can still accept then.
  assign pop       = (state == REQ && SDR_ACK && SDR_RDY) || (state == WAIT && SDR_RDY);
  assign accept    = PROG_WE && !taken && (!full || pop || merge_ok);
  assign push      = accept && !merge_ok;
  assign merge     = accept && merge_ok;
  assign remaining = (count > ONE) || push;

  garegga_prog_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (CLK),
    .resetn      (RESET_N),
    .push        (push),
    .push_entry  (req_entry),
    .pop         (pop),
    .merge       (merge),
    .merge_entry (merge_entry),
    .head        (head),
    .tail        (tail),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (!empty || push) state_nx = REQ;
      REQ: begin
        if (SDR_ACK && SDR_RDY) state_nx = remaining ? REQ : IDLE;
        else if (SDR_ACK)       state_nx = WAIT;
      end
      WAIT: if (SDR_RDY) state_nx = remaining ? REQ : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state    <= IDLE;
      taken    <= 1'b0;
      PROG_RDY <= 1'b0;
    end else begin
      state    <= state_nx;
      PROG_RDY <= accept;
      if (!PROG_WE)    taken <= 1'b0;
      else if (accept) taken <= 1'b1;
    end
  end

  assign SDR_WR    = (state == REQ);
  assign PROG_BUSY = !empty || (state != IDLE);
  assign SDR_ADDR  = empty ? '0       : AW'(head.addr);
  assign SDR_BA    = empty ? 2'b00    : head.ba;
  assign SDR_DIN   = empty ? 16'h0000 : head.data;
  assign SDR_DIN_M = empty ? MASK_RST : head.mask;

endmodule

// File: tb/tb_garegga_prog_wr.sv
// tb/tb_garegga_prog_wr.sv - directed self-checking bench for garegga_prog_wr
module tb_garegga_prog_wr;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [21:0] PROG_ADDR;
  logic [15:0] PROG_DATA;
  logic [1:0]  PROG_MASK;
  logic [1:0]  PROG_BA;
  logic        PROG_WE;
  logic        PROG_RDY;
  logic        DOWNLOADING;
  logic        PROG_BUSY;
  logic [21:0] SDR_ADDR;
  logic [1:0]  SDR_BA;
  logic [15:0] SDR_DIN;
  logic [1:0]  SDR_DIN_M;
  logic        SDR_WR;
  logic        SDR_ACK;
  logic        SDR_RDY;

  int checks = 0;
  int errors = 0;
  int rdy_cnt;

  always #5 CLK = ~CLK;

  garegga_prog_wr dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA), .PROG_MASK(PROG_MASK),
    .PROG_BA(PROG_BA), .PROG_WE(PROG_WE), .PROG_RDY(PROG_RDY),
    .DOWNLOADING(DOWNLOADING), .PROG_BUSY(PROG_BUSY),
    .SDR_ADDR(SDR_ADDR), .SDR_BA(SDR_BA), .SDR_DIN(SDR_DIN), .SDR_DIN_M(SDR_DIN_M),
    .SDR_WR(SDR_WR), .SDR_ACK(SDR_ACK), .SDR_RDY(SDR_RDY)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [21:0] a, input logic [1:0] ba, input logic [1:0] m, input logic [15:0] d);
    PROG_ADDR = a; PROG_BA = ba; PROG_MASK = m; PROG_DATA = d; PROG_WE = 1'b1;
    tick();
    chk("wr_rdy", 32'(PROG_RDY), 32'd1);
    PROG_WE = 1'b0;
    tick();
  endtask

  task automatic drain_one(input string tag, input logic [15:0] din);
    chk({tag, "_wr"}, 32'(SDR_WR), 32'd1);
    chk({tag, "_din"}, 32'(SDR_DIN), 32'(din));
    SDR_ACK = 1'b1;
    tick();
    chk({tag, "_wr_drop"}, 32'(SDR_WR), 32'd0);
    SDR_ACK = 1'b0; SDR_RDY = 1'b1;
    tick();
    SDR_RDY = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0; PROG_WE = 1'b0; PROG_ADDR = '0; PROG_DATA = '0; PROG_MASK = 2'b00;
    PROG_BA = 2'b00; DOWNLOADING = 1'b1; SDR_ACK = 1'b0; SDR_RDY = 1'b0;
    tick(); tick();
    chk("rst_rdy", 32'(PROG_RDY), 32'd0);
    chk("rst_busy", 32'(PROG_BUSY), 32'd0);
    chk("rst_wr", 32'(SDR_WR), 32'd0);
    chk("rst_addr", 32'(SDR_ADDR), 32'd0);
    chk("rst_ba", 32'(SDR_BA), 32'd0);
    chk("rst_din", 32'(SDR_DIN), 32'd0);
    chk("rst_mask", 32'(SDR_DIN_M), 32'd3);
    RESET_N = 1'b1;
    tick();

    // single write
    PROG_ADDR = 22'h000123; PROG_BA = 2'd1; PROG_MASK = 2'b10; PROG_DATA = 16'h5A5A; PROG_WE = 1'b1;
    tick();
    chk("single_rdy", 32'(PROG_RDY), 32'd1);
    chk("single_wr", 32'(SDR_WR), 32'd1);
    chk("single_addr", 32'(SDR_ADDR), 32'h123);
    chk("single_ba", 32'(SDR_BA), 32'd1);
    chk("single_din", 32'(SDR_DIN), 32'h5A5A);
    chk("single_mask", 32'(SDR_DIN_M), 32'd2);
    chk("single_busy", 32'(PROG_BUSY), 32'd1);
    PROG_WE = 1'b0;
    tick();
    chk("single_rdy_pulse", 32'(PROG_RDY), 32'd0);
    chk("single_wr_hold", 32'(SDR_WR), 32'd1);
    SDR_ACK = 1'b1;
    tick();
    chk("single_wr_ack", 32'(SDR_WR), 32'd0);
    SDR_ACK = 1'b0; SDR_RDY = 1'b1;
    tick();
    SDR_RDY = 1'b0;
    chk("single_busy_done", 32'(PROG_BUSY), 32'd0);

    // held WE for 10 cycles
    PROG_ADDR = 22'h000040; PROG_BA = 2'd0; PROG_MASK = 2'b00; PROG_DATA = 16'h3333; PROG_WE = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      rdy_cnt += int'(PROG_RDY);
    end
    PROG_WE = 1'b0;
    chk("held_rdy_count", 32'(rdy_cnt), 32'd1);
    SDR_ACK = 1'b1; tick(); SDR_ACK = 1'b0;
    SDR_RDY = 1'b1; tick(); SDR_RDY = 1'b0;
    chk("held_single_txn_busy", 32'(PROG_BUSY), 32'd0);
    chk("held_single_txn_wr", 32'(SDR_WR), 32'd0);

    // backpressure: 5 writes, controller silent
    DOWNLOADING = 1'b0;
    wr(22'h10, 2'd0, 2'b00, 16'hA000);
    wr(22'h11, 2'd0, 2'b00, 16'hA001);
    wr(22'h12, 2'd0, 2'b00, 16'hA002);
    wr(22'h13, 2'd0, 2'b00, 16'hA003);
    PROG_ADDR = 22'h14; PROG_DATA = 16'hA004; PROG_WE = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      rdy_cnt += int'(PROG_RDY);
    end
    chk("bp_full_no_rdy", 32'(rdy_cnt), 32'd0);
    chk("bp_head_din", 32'(SDR_DIN), 32'hA000);
    SDR_ACK = 1'b1; tick(); SDR_ACK = 1'b0;
    chk("bp_full_still", 32'(PROG_RDY), 32'd0);
    SDR_RDY = 1'b1; tick(); SDR_RDY = 1'b0;
    chk("bp_fifth_rdy", 32'(PROG_RDY), 32'd1);
    PROG_WE = 1'b0;
    drain_one("bp1", 16'hA001);
    drain_one("bp2", 16'hA002);
    drain_one("bp3", 16'hA003);
    drain_one("bp4", 16'hA004);
    chk("bp_busy_done", 32'(PROG_BUSY), 32'd0);
    DOWNLOADING = 1'b1;

    // ACK+RDY together in REQ while a push lands on a full FIFO
    wr(22'h20, 2'd2, 2'b00, 16'hB000);
    wr(22'h21, 2'd2, 2'b00, 16'hB001);
    wr(22'h22, 2'd2, 2'b00, 16'hB002);
    wr(22'h23, 2'd2, 2'b00, 16'hB003);
    PROG_ADDR = 22'h24; PROG_DATA = 16'hB004; PROG_WE = 1'b1;
    SDR_ACK = 1'b1; SDR_RDY = 1'b1;
    tick();
    chk("simul_rdy", 32'(PROG_RDY), 32'd1);
    chk("simul_wr", 32'(SDR_WR), 32'd1);
    chk("simul_din", 32'(SDR_DIN), 32'hB001);
    PROG_WE = 1'b0; SDR_ACK = 1'b0; SDR_RDY = 1'b0;
    tick();
    PROG_DATA = 16'hDEAD; PROG_WE = 1'b1;
    tick();
    chk("simul_still_full", 32'(PROG_RDY), 32'd0);
    PROG_WE = 1'b0;
    tick();
    drain_one("simul1", 16'hB001);
    drain_one("simul2", 16'hB002);
    drain_one("simul3", 16'hB003);
    drain_one("simul4", 16'hB004);
    chk("simul_busy_done", 32'(PROG_BUSY), 32'd0);

    // byte merge behind a busy head
    wr(22'h100, 2'd0, 2'b00, 16'h0101);
    SDR_ACK = 1'b1; tick(); SDR_ACK = 1'b0;
    wr(22'h200, 2'd0, 2'b10, 16'h1111);
    wr(22'h200, 2'd0, 2'b01, 16'h2222);
    SDR_RDY = 1'b1; tick(); SDR_RDY = 1'b0;
    chk("merge_addr", 32'(SDR_ADDR), 32'h200);
`ifdef GAREGGA_PROG_MERGE_EN
    chk("merge_mask", 32'(SDR_DIN_M), 32'd0);
    drain_one("merge_one", 16'h2211);
`else
    chk("nomerge_mask_a", 32'(SDR_DIN_M), 32'd2);
    drain_one("nomerge_a", 16'h1111);
    chk("nomerge_mask_b", 32'(SDR_DIN_M), 32'd1);
    drain_one("nomerge_b", 16'h2222);
`endif
    chk("merge_busy_done", 32'(PROG_BUSY), 32'd0);

    // reset while waiting with 3 entries
    wr(22'h300, 2'd3, 2'b00, 16'hC000);
    wr(22'h301, 2'd3, 2'b00, 16'hC001);
    wr(22'h302, 2'd3, 2'b00, 16'hC002);
    SDR_ACK = 1'b1; tick(); SDR_ACK = 1'b0;
    chk("rstmid_busy_before", 32'(PROG_BUSY), 32'd1);
    RESET_N = 1'b0;
    tick();
    chk("rstmid_wr", 32'(SDR_WR), 32'd0);
    chk("rstmid_busy", 32'(PROG_BUSY), 32'd0);
    chk("rstmid_mask", 32'(SDR_DIN_M), 32'd3);
    RESET_N = 1'b1;
    tick();
    chk("rstmid_busy_after", 32'(PROG_BUSY), 32'd0);
    chk("rstmid_wr_after", 32'(SDR_WR), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/garegga_prog_wr.md
# garegga_prog_wr

Download-side write responder for the game's ROM loader. Accepts the single-word SDRAM programming requests (`PROG_ADDR`/`PROG_DATA`/`PROG_MASK`/`PROG_BA`/`PROG_WE`) produced during ROM download and answers with `PROG_RDY`. Buffers requests in a small FIFO and replays each one to the SDRAM controller's write port with a req/ack/rdy handshake. Sits between the game's ROM loader and the SDRAM controller, in the `CLK` domain.

## Interface
Parameters:
- `DEPTH`, 4 — FIFO entries; power of two, minimum 2.
- `AW`, 22 — word address width.

Ports:
- `CLK` in 1 — the single clock; all logic is on its rising edge.
- `RESET_N` in 1 — reset, synchronous and active-low.
- `PROG_ADDR` in AW — word address.
- `PROG_DATA` in 16 — write data; the same byte is duplicated in both halves.
- `PROG_MASK` in 2 — byte mask; 1 = byte NOT written.
- `PROG_BA` in 2 — SDRAM bank.
- `PROG_WE` in 1 — write request, level; held by the loader until `PROG_RDY`.
- `PROG_RDY` out 1 — one-cycle pulse: request accepted.
- `DOWNLOADING` in 1 — a download is in progress.
- `PROG_BUSY` out 1 — FIFO not empty or an SDRAM write is outstanding; feeds `DWNLD_BUSY`.
- `SDR_ADDR` out AW, `SDR_BA` out 2, `SDR_DIN` out 16, `SDR_DIN_M` out 2 — the head entry.
- `SDR_WR` out 1 — write request to the SDRAM controller.
- `SDR_ACK` in 1 — controller has latched the request.
- `SDR_RDY` in 1 — controller has completed the write.

## Operation
- Accept rule: the block accepts on a cycle where `PROG_WE`=1, the `taken` flag is 0, and the FIFO is not full.
  - On accept, the entry is written at the tail and `taken` is set.
  - `taken` clears on any cycle where `PROG_WE`=0.
  - This guarantees exactly one accept per `PROG_WE` assertion.
- Full FIFO: no accept and no `PROG_RDY`. The request stays pending and is accepted on the first cycle a slot frees up.
- Drain FSM states:
  - IDLE: if the FIFO is not empty, go to REQ.
  - REQ: `SDR_WR`=1 with the head fields; when `SDR_ACK`=1, go to WAIT and drop `SDR_WR`.
  - WAIT: when `SDR_RDY`=1, pop the head; go to REQ if further entries remain, otherwise IDLE.
- While `SDR_WR`=1, `SDR_ADDR`/`SDR_BA`/`SDR_DIN`/`SDR_DIN_M` stay stable.
- `SDR_ACK` and `SDR_RDY` in the same cycle in REQ: treated as completed; pop and move on.
- Accept and pop in the same cycle: both happen; the count is unchanged.
- Pointers are log2(`DEPTH`) bits and wrap naturally. The count is log2(`DEPTH`)+1 bits.
- `PROG_BUSY` = (count ≠ 0) | (state ≠ IDLE). It is independent of `DOWNLOADING`.
- If `DOWNLOADING`=0 while `PROG_WE`=1, the request is still accepted and drained. `DOWNLOADING` is informational only and gates nothing.
- `RESET_N`=0 mid-operation:
  - FIFO flushed, state returns to IDLE, `taken` cleared.
  - In-flight `SDR_WR` dropped the next edge; the entry is lost.

## Timing
- Reset values: `PROG_RDY`=0, `PROG_BUSY`=0, `SDR_WR`=0, `SDR_ADDR`=0, `SDR_BA`=0, `SDR_DIN`=0, `SDR_DIN_M`=2'b11.
- Accept at edge N → `PROG_RDY`=1 during cycle N+1 only. The loader sees it and drops `PROG_WE`.
- First entry into an empty FIFO at edge N → `SDR_WR`=1 from N+1. FSM latency is 1 cycle.
- `SDR_ACK` at edge M → `SDR_WR`=0 from M+1.
- `SDR_RDY` at edge K → pop at K. The next `SDR_WR` rises at K+1 if further entries remain.
- Sustained throughput: 1 word per controller round trip plus 1 cycle.

## Configuration
- `GAREGGA_PROG_MERGE_EN` defined — byte merge.
  - Condition: an accepted request has the same `PROG_ADDR`/`PROG_BA` as the tail entry, that tail entry is not the head currently in REQ/WAIT, and the two masks are disjoint (`PROG_MASK` | tail mask = 2'b11 before the merge… i.e. `~PROG_MASK & ~tail_mask` = 0).
  - Action: the request merges into the tail instead of taking a new slot. Enabled bytes are taken from `PROG_DATA`, and the mask becomes the AND of the two masks.
  - `PROG_RDY` still pulses. A merge is allowed even when the FIFO is full.
- Macro undefined: every accept takes a slot; there is no comparator logic.

## Structure
- Package `garegga_prog_pkg` holds:
  - the FIFO entry struct {addr[AW], ba[2], data[16], mask[2]};
  - the drain state enum {IDLE, REQ, WAIT};
  - the reset-mask constant 2'b11.
- Sub-module `garegga_prog_fifo` contains the storage, pointers and count, with push/pop/merge ports. The FSM and accept logic live in the top module.

## Test plan
- Single write: `PROG_WE`=1 with ADDR=0x000123, BA=1, MASK=2'b10, DATA=0x5A5A → `PROG_RDY` pulses at N+1; `SDR_WR` rises at N+1 with the same fields; ACK then RDY → `PROG_BUSY`=0.
- Held WE: `PROG_WE` held high for 10 cycles → exactly one `PROG_RDY` and one `SDR_WR` transaction.
- Backpressure: controller withholds `SDR_ACK` while 5 writes are issued → 4 accepted; the 5th `PROG_RDY` appears 1 cycle after the first `SDR_RDY` pop. `SDR_DIN` order matches the issue order.
- Merge (macro on): head busy in WAIT, then writes 0x000200 with mask 10 (0x11), then 0x000200 with mask 01 (0x22) → a single entry with DIN=0x2211 and mask 00. With the macro off → two transactions.
- Simultaneous ACK+RDY in REQ, and a push in the same cycle as a pop with count=4 → the count stays at 4 and no entry is lost or duplicated.
- `RESET_N`=0 while in WAIT with 3 entries → next cycle `SDR_WR`=0, `PROG_BUSY`=0, and `SDR_DIN_M`=2'b11.
